// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one unsigned fixed-point divider among NREQ requesters.
// Optional divider watchdog is compiled in with `define DIV_TIMEOUT_EN.
module div_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int TMO  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] dividend,
    input  logic [NREQ*W-1:0] divisor,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      q_out,
    output logic              dvz_out,
    output logic              ovf_out,
    output logic              div_start,
    output logic [W-1:0]      div_a,
    output logic [W-1:0]      div_b,
    input  logic              div_busy,
    input  logic              div_valid,
    input  logic              div_dvz,
    input  logic              div_ovf,
    input  logic [W-1:0]      div_q
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_DIV = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   owner_r;
    logic [PW-1:0]   win_s;
    logic [NREQ-1:0] win_oh_s;
    logic            tmo_hit_s;

    // Scan from the far end back toward p so the nearest set bit at or after p wins.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] pick;
        logic [PW:0]   s;
        pick = p;
        for (int k = NREQ - 1; k >= 0; k--) begin
            s = {1'b0, p} + (PW+1)'(k);
            if (s >= (PW+1)'(NREQ)) begin
                s = s - (PW+1)'(NREQ);
            end else begin
                s = s;
            end
            if (r[s[PW-1:0]]) begin
                pick = s[PW-1:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] o);
        logic [PW-1:0] n;
        if (o == PW'(NREQ - 1)) begin
            n = {PW{1'b0}};
        end else begin
            n = o + PW'(1);
        end
        return n;
    endfunction

    // Winner selection for the IDLE cycle.
    always_comb begin
        win_s    = rr_pick(req, ptr_r);
        win_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
    end

`ifdef DIV_TIMEOUT_EN
    localparam int CW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;
    logic [CW-1:0] tmo_cnt_r;

    // Watchdog: cleared on issue, counts WAIT cycles; hit marks the TMO-th one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_r <= {CW{1'b0}};
        end else if (state_r == ISSUE) begin
            tmo_cnt_r <= {CW{1'b0}};
        end else if (state_r == WAIT_DIV) begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign tmo_hit_s = (tmo_cnt_r == CW'(TMO - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Arbitration FSM with all client and divider-side outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            ptr_r     <= {PW{1'b0}};
            owner_r   <= {PW{1'b0}};
            gnt       <= {NREQ{1'b0}};
            done      <= {NREQ{1'b0}};
            q_out     <= {W{1'b0}};
            dvz_out   <= 1'b0;
            ovf_out   <= 1'b0;
            div_start <= 1'b0;
            div_a     <= {W{1'b0}};
            div_b     <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done      <= {NREQ{1'b0}};
                    q_out     <= {W{1'b0}};
                    dvz_out   <= 1'b0;
                    ovf_out   <= 1'b0;
                    div_start <= 1'b0;
                    if (req != {NREQ{1'b0}}) begin
                        gnt     <= win_oh_s;
                        owner_r <= win_s;
                        div_a   <= dividend[win_s*W +: W];
                        div_b   <= divisor[win_s*W +: W];
                        state_r <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    div_start <= 1'b1;
                    state_r   <= WAIT_DIV;
                end
                WAIT_DIV: begin
                    div_start <= 1'b0;
                    // Result is loaded straight into the outputs so done shows up in RESP.
                    if (div_dvz) begin
                        done    <= gnt;
                        q_out   <= {W{1'b0}};
                        dvz_out <= 1'b1;
                        ovf_out <= 1'b0;
                        state_r <= RESP;
                    end else if (div_ovf || tmo_hit_s) begin
                        done    <= gnt;
                        q_out   <= {W{1'b0}};
                        dvz_out <= 1'b0;
                        ovf_out <= 1'b1;
                        state_r <= RESP;
                    end else if (div_valid) begin
                        done    <= gnt;
                        q_out   <= div_q;
                        dvz_out <= 1'b0;
                        ovf_out <= 1'b0;
                        state_r <= RESP;
                    end else begin
                        state_r <= WAIT_DIV;
                    end
                end
                RESP: begin
                    done    <= {NREQ{1'b0}};
                    q_out   <= {W{1'b0}};
                    dvz_out <= 1'b0;
                    ovf_out <= 1'b0;
                    gnt     <= {NREQ{1'b0}};
                    ptr_r   <= next_ptr(owner_r);
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    div_share_arbiter_chk #(
        .NREQ (NREQ),
        .TMO  (TMO)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .gnt       (gnt),
        .done      (done),
        .div_start (div_start),
        .div_busy  (div_busy)
    );
endmodule

// Protocol checker for the arbiter: ownership, done routing and divider handshake.
module div_share_arbiter_chk #(
    parameter int NREQ = 4,
    parameter int TMO  = 255
) (
    input logic            clk,
    input logic            rst,
    input logic [NREQ-1:0] gnt,
    input logic [NREQ-1:0] done,
    input logic            div_start,
    input logic            div_busy
);
    a_params:    assert property (@(posedge clk) (NREQ >= 2) && (NREQ <= 8) && (TMO >= 1));
    a_gnt_oh:    assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
    a_done_own:  assert property (@(posedge clk) disable iff (!rst) (done != {NREQ{1'b0}}) |-> (done == gnt));
    a_start_idl: assert property (@(posedge clk) disable iff (!rst) div_start |-> !div_busy);
endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter with a behavioural divider model.
module tb_div_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TMO  = 20;

    typedef struct {
        int         owner;
        logic [W-1:0] q;
        logic       dvz;
        logic       ovf;
        int         lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] dividend;
    logic [NREQ*W-1:0] divisor;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      q_out;
    logic              dvz_out;
    logic              ovf_out;
    logic              div_start;
    logic [W-1:0]      div_a;
    logic [W-1:0]      div_b;
    logic              div_busy;
    logic              div_valid;
    logic              div_dvz;
    logic              div_ovf;
    logic [W-1:0]      div_q;

    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];
    int jobs_req  [NREQ];
    int jobs_done [NREQ];
    exp_t sb[$];

    int chk_cnt   = 0;
    int pass_cnt  = 0;
    int cyc       = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int m_ptr     = 0;
    int lat       = 2;
    bit silent    = 1'b0;
    bit force_ovf = 1'b0;
    bit force_valid = 1'b0;
    logic [NREQ-1:0] prev_done = '0;

    int   d_cnt  = 0;
    bit   d_pend = 1'b0;
    logic [W-1:0] d_a, d_b;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (jobs_req[i] > jobs_done[i]);
            dividend[i*W +: W] = op_a[i];
            divisor[i*W +: W]  = op_b[i];
        end
    end

    div_share_arbiter #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .dividend(dividend), .divisor(divisor),
        .gnt(gnt), .done(done), .q_out(q_out), .dvz_out(dvz_out), .ovf_out(ovf_out),
        .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_busy(div_busy),
        .div_valid(div_valid), .div_dvz(div_dvz), .div_ovf(div_ovf), .div_q(div_q)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Divider: responds lat cycles after seeing Start; quotient bus is noise otherwise.
    always @(negedge clk) begin
        div_valid = 1'b0;
        div_dvz   = 1'b0;
        div_ovf   = 1'b0;
        div_q     = W'($urandom);
        if (rst !== 1'b1) begin
            d_pend   = 1'b0;
            div_busy = 1'b0;
        end else begin
            if (d_pend) begin
                if (d_cnt == 0) begin
                    d_pend   = 1'b0;
                    div_busy = 1'b0;
                    if (!silent) begin
                        if (d_b == '0) begin
                            div_dvz = 1'b1;
                            div_q   = 16'hdead;
                        end else begin
                            div_valid = 1'b1;
                            div_q     = d_a / d_b;
                        end
                        if (force_ovf) div_ovf = 1'b1;
                        if (force_valid) div_valid = 1'b1;
                    end
                end else begin
                    d_cnt--;
                    div_busy = 1'b1;
                end
            end
            if (div_start === 1'b1) begin
                d_pend = 1'b1;
                d_cnt  = lat;
                d_a    = div_a;
                d_b    = div_b;
            end
        end
    end

    // Output monitor: pops the scoreboard on each done pulse.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst !== 1'b1) begin
            prev_done = '0;
        end else begin
            if (div_start === 1'b1) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (prev_done != '0)
                check_val("done_clear", {10'd0, done, q_out, dvz_out, ovf_out}, 32'd0);
            if (done != '0) begin
                if (sb.size() == 0) begin
                    check_val("extra_done", {28'd0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("gnt", 32'(gnt), 32'd1 << e.owner);
                    check_val("done", 32'(done), 32'd1 << e.owner);
                    check_val("q_out", 32'(q_out), 32'(e.q));
                    check_val("dvz_out", 32'(dvz_out), 32'(e.dvz));
                    check_val("ovf_out", 32'(ovf_out), 32'(e.ovf));
                    check_val("latency", cyc - start_cyc, e.lat);
                    jobs_done[e.owner]++;
                end
            end
            prev_done = done;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_jobs(input int n0, input int n1, input int n2, input int n3);
        jobs_req[0] += n0;
        jobs_req[1] += n1;
        jobs_req[2] += n2;
        jobs_req[3] += n3;
    endtask

    // Reference round-robin: pushes the expected completion order for all pending jobs.
    task automatic predict();
        int left [NREQ];
        int total;
        int o;
        int idx;
        exp_t e;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            left[i] = jobs_req[i] - jobs_done[i];
            total += left[i];
        end
        repeat (total) begin
            o = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (o < 0 && left[idx] > 0) o = idx;
            end
            left[o]--;
            e.owner = o;
            e.lat   = lat + 2;
            e.q     = '0;
            e.dvz   = 1'b0;
            e.ovf   = 1'b0;
            if (silent || lat > TMO) begin
                e.ovf = 1'b1;
                e.lat = TMO;
            end else if (op_b[o] == '0) begin
                e.dvz = 1'b1;
            end else if (force_ovf) begin
                e.ovf = 1'b1;
            end else begin
                e.q = op_a[o] / op_b[o];
            end
            sb.push_back(e);
            m_ptr = (o + 1) % NREQ;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check_val("drain", sb.size(), 0);
        sb.delete();
        tick(3);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        check_val("rst_outs", {5'd0, gnt, done, q_out, dvz_out, ovf_out, div_start}, 32'd0);
        check_val("rst_ops", {div_a, div_b}, 32'd0);
        sb.delete();
        m_ptr = 0;
        rst = 1'b1;
        tick(2);
    endtask

    initial begin
        int s0;
        int n;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = 16'd1;
            jobs_req[i]  = 0;
            jobs_done[i] = 0;
        end
        tick(1);
        do_reset();

        // Single job: check grant, start timing and operand latch.
        op_a[0] = 16'd100;
        op_b[0] = 16'd7;
        lat = 3;
        s0 = start_cnt;
        add_jobs(1, 0, 0, 0);
        predict();
        tick(1);
        check_val("t1_gnt", 32'(gnt), 32'h1);
        check_val("t1_start0", 32'(div_start), 32'd0);
        check_val("t1_div_a", 32'(div_a), 32'd100);
        check_val("t1_div_b", 32'(div_b), 32'd7);
        tick(1);
        check_val("t1_start1", 32'(div_start), 32'd1);
        tick(1);
        check_val("t1_start2", 32'(div_start), 32'd0);
        check_val("t1_hold_a", 32'(div_a), 32'd100);
        drain(50);
        check_val("t1_starts", start_cnt - s0, 1);

        // Two requesters from reset, then probe the pointer with 1001.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = W'($urandom_range(65535, 1));
            op_b[i] = W'($urandom_range(255, 1));
        end
        lat = 1;
        s0 = start_cnt;
        add_jobs(0, 1, 1, 0);
        predict();
        drain(100);
        add_jobs(1, 0, 0, 1);
        predict();
        drain(100);
        check_val("t2_starts", start_cnt - s0, 4);

        // All four requesting, two jobs each.
        do_reset();
        lat = 2;
        s0 = start_cnt;
        add_jobs(2, 2, 2, 2);
        predict();
        drain(300);
        check_val("t3_starts", start_cnt - s0, 8);

        // Exceptions and flag priority.
        s0 = start_cnt;
        op_a[2] = 16'd1234;
        op_b[2] = 16'd0;
        add_jobs(0, 0, 1, 0);
        predict();
        drain(60);
        force_ovf = 1'b1;
        op_a[2] = 16'd1000;
        op_b[2] = 16'd5;
        add_jobs(0, 0, 1, 0);
        predict();
        drain(60);
        force_ovf = 1'b0;
        lat = 0;
        op_a[3] = 16'hffff;
        op_b[3] = 16'd1;
        add_jobs(0, 0, 0, 1);
        predict();
        drain(60);
        force_ovf = 1'b1;
        force_valid = 1'b1;
        op_a[1] = 16'd77;
        op_b[1] = 16'd0;
        add_jobs(0, 1, 0, 0);
        predict();
        drain(60);
        force_ovf = 1'b0;
        force_valid = 1'b0;
        check_val("t4_starts", start_cnt - s0, 4);

        // Reset in the middle of a WAIT: job dropped, pointer back to 0.
        s0 = start_cnt;
        lat = 10;
        op_a[1] = 16'd500;
        op_b[1] = 16'd9;
        op_a[3] = 16'd60000;
        op_b[3] = 16'd250;
        add_jobs(0, 1, 0, 0);
        predict();
        n = 0;
        while (gnt !== 4'b0010 && n < 10) begin
            tick(1);
            n++;
        end
        check_val("t5_gnt", 32'(gnt), 32'h2);
        tick(4);
        rst = 1'b0;
        tick(1);
        check_val("t5_rst_outs", {5'd0, gnt, done, q_out, dvz_out, ovf_out, div_start}, 32'd0);
        check_val("t5_rst_ops", {div_a, div_b}, 32'd0);
        add_jobs(0, 0, 0, 1);
        sb.delete();
        m_ptr = 0;
        tick(1);
        rst = 1'b1;
        predict();
        drain(100);
        check_val("t5_starts", start_cnt - s0, 3);

`ifdef DIV_TIMEOUT_EN
        // Silent divider, then a pulse arriving after the watchdog fired.
        s0 = start_cnt;
        silent = 1'b1;
        add_jobs(1, 0, 0, 0);
        predict();
        drain(100);
        silent = 1'b0;
        lat = TMO + 5;
        add_jobs(1, 0, 0, 0);
        predict();
        drain(100);
        tick(30);
        check_val("t6_starts", start_cnt - s0, 2);
`endif

        tick(2);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
